// File: rtl/tmds_serializer.sv
// 10:1 TMDS serializer for R/G/B plus the TMDS clock channel, in the clk_fast (10x pixel) domain.
// A one-entry holding buffer decouples upstream pixel logic; idle control words fill any gaps.
module tmds_serializer #(
  parameter logic [9:0] IDLE_WORD   = 10'b1101010100,
  parameter logic [9:0] CLK_PATTERN = 10'b0000011111,
  parameter int         UF_CNT_W    = 8
) (
  input  logic                clk_fast,
  input  logic                rst,
  input  logic [9:0]          tmds_r,
  input  logic [9:0]          tmds_g,
  input  logic [9:0]          tmds_b,
  input  logic                word_valid,
  output logic                word_ready,
  input  logic                underflow_clr,
  output logic                ser_r,
  output logic                ser_g,
  output logic                ser_b,
  output logic                ser_clk,
  output logic                load_tick,
  output logic                underflow,
  output logic [UF_CNT_W-1:0] uf_count
);

  localparam logic [3:0]          LAST_BIT = 4'd9;
  localparam logic [UF_CNT_W-1:0] UF_ZERO  = {UF_CNT_W{1'b0}};
  localparam logic [UF_CNT_W-1:0] UF_ONE   = {{(UF_CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [UF_CNT_W-1:0] sat_inc(input logic [UF_CNT_W-1:0] value);
    if (&value) begin
      sat_inc = value;
    end else begin
      sat_inc = value + UF_ONE;
    end
  endfunction

  logic [3:0]          bit_cnt_r;
  logic [9:0]          shift_red_r, shift_grn_r, shift_blu_r, shift_clk_r;
  logic [9:0]          hold_red_r, hold_grn_r, hold_blu_r;
  logic                hold_full_r;
  logic                underflow_r;
  logic [UF_CNT_W-1:0] uf_count_r;

  logic                boundary_s;
  logic                load_hold_s;
  logic                uf_event_s;
  logic [9:0]          next_red_s, next_grn_s, next_blu_s;

  assign boundary_s = (bit_cnt_r == LAST_BIT);
  // At a boundary the hold slot refills only if it is being drained; mid-period only if empty.
  assign load_hold_s = word_valid && (boundary_s ? hold_full_r : !hold_full_r);
  assign uf_event_s  = boundary_s && !hold_full_r && !word_valid;

  assign word_ready = !hold_full_r || boundary_s;
  assign load_tick  = boundary_s;
  assign ser_r      = shift_red_r[0];
  assign ser_g      = shift_grn_r[0];
  assign ser_b      = shift_blu_r[0];
  assign ser_clk    = shift_clk_r[0];
  assign underflow  = underflow_r;
  assign uf_count   = uf_count_r;

  // Select the word loaded at the boundary: held word first, then bypass, else idle.
  always_comb begin
    next_red_s = IDLE_WORD;
    next_grn_s = IDLE_WORD;
    next_blu_s = IDLE_WORD;
    if (hold_full_r) begin
      next_red_s = hold_red_r;
      next_grn_s = hold_grn_r;
      next_blu_s = hold_blu_r;
    end else if (word_valid) begin
      next_red_s = tmds_r;
      next_grn_s = tmds_g;
      next_blu_s = tmds_b;
    end else begin
      next_red_s = IDLE_WORD;
      next_grn_s = IDLE_WORD;
      next_blu_s = IDLE_WORD;
    end
  end

  // Pixel-period bit counter, 0..9.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      bit_cnt_r <= 4'd0;
    end else if (boundary_s) begin
      bit_cnt_r <= 4'd0;
    end else begin
      bit_cnt_r <= bit_cnt_r + 4'd1;
    end
  end

  // Output shift registers: reload at the word boundary, shift right otherwise.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      shift_red_r <= IDLE_WORD;
      shift_grn_r <= IDLE_WORD;
      shift_blu_r <= IDLE_WORD;
      shift_clk_r <= CLK_PATTERN;
    end else if (boundary_s) begin
      shift_red_r <= next_red_s;
      shift_grn_r <= next_grn_s;
      shift_blu_r <= next_blu_s;
      shift_clk_r <= CLK_PATTERN;
    end else begin
      shift_red_r <= {1'b0, shift_red_r[9:1]};
      shift_grn_r <= {1'b0, shift_grn_r[9:1]};
      shift_blu_r <= {1'b0, shift_blu_r[9:1]};
      shift_clk_r <= {1'b0, shift_clk_r[9:1]};
    end
  end

  // One-entry holding buffer.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      hold_red_r  <= 10'd0;
      hold_grn_r  <= 10'd0;
      hold_blu_r  <= 10'd0;
      hold_full_r <= 1'b0;
    end else if (load_hold_s) begin
      hold_red_r  <= tmds_r;
      hold_grn_r  <= tmds_g;
      hold_blu_r  <= tmds_b;
      hold_full_r <= 1'b1;
    end else if (boundary_s) begin
      hold_full_r <= 1'b0;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

  // Sticky underflow flag and saturating count; a clear coinciding with an underflow restarts at 1.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      underflow_r <= 1'b0;
      uf_count_r  <= UF_ZERO;
    end else if (uf_event_s) begin
      underflow_r <= 1'b1;
      uf_count_r  <= sat_inc(underflow_clr ? UF_ZERO : uf_count_r);
    end else if (underflow_clr) begin
      underflow_r <= 1'b0;
      uf_count_r  <= UF_ZERO;
    end else begin
      underflow_r <= underflow_r;
      uf_count_r  <= uf_count_r;
    end
  end

endmodule
